// File: rtl/serial_tx_if.sv
// rtl/serial_tx_if.sv - producer-side handshake and serial line bundle for serial_tx
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_out;
    logic              busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_out,
        output busy
    );
endinterface

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - start/data/stop serial transmitter, LSB first, registered line output
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    serial_tx_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [IW-1:0]     idx, idx_next;
    logic [DATA_W-1:0] shreg, shreg_next, shifted;
    logic              line, line_next;
    logic              cnt_last, idx_last;

    assign cnt_last = (cnt == CW'(CLKS_PER_BIT - 1));
    assign idx_last = (idx == IW'(DATA_W - 1));
    assign shifted  = shreg >> 1;

    assign bus.tx_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.tx_out   = line;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            line  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shreg <= shreg_next;
            line  <= line_next;
        end
    end

    // The line level for the next cycle is decided here so tx_out comes straight from a flop.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        line_next  = line;
        case (state)
            IDLE: begin
                cnt_next  = '0;
                idx_next  = '0;
                line_next = 1'b1;
                if (bus.tx_valid) begin
                    state_next = START;
                    shreg_next = bus.tx_data;
                    line_next  = 1'b0;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    state_next = DATA;
                    line_next  = shreg[0];
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_next = '0;
                    if (idx_last) begin
                        state_next = STOP;
                        line_next  = 1'b1;
                    end else begin
                        idx_next   = idx + IW'(1);
                        shreg_next = shifted;
                        line_next  = shifted[0];
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
